frame_capture_buf: RTL and testbench
====================================

// Module: frame_capture_buf
// PURPOSE
//  Synthesizable frame receiver: captures a byte stream framed by vin into on-chip buffer,
//  detects end-of-frame via idle-gap timeout, then holds frame for random-access readout
//  until acknowledged. Generalises the sim-only receiver: param width/depth, overflow and
//  missed-frame flags, readout port. Sits at MAC/PHY-side taps for in-fabric frame capture.
// PARAMETERS
//  W        8     data width (bits)
//  DEPTH    2048  buffer depth (words); power of 2 not required
//  TIMEOUT  0     idle cycles closing a frame; 0 = first idle cycle closes it
//  LEN_W    $clog2(DEPTH+1)  width of len/rd_addr-related counters (derived, do not override)
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  din        in   W      stream data
//  vin        in   1      din valid; frame = contiguous vin (gaps < TIMEOUT allowed)
//  ack        in   1      release captured frame, re-arm
//  rd_addr    in   LEN_W  readout address
//  rd_data    out  W      buffer word at rd_addr, 1-cycle latency
//  frame_val  out  1      level: frame captured, buffer frozen
//  frame_len  out  LEN_W  words stored (saturates at DEPTH)
//  ovf        out  1      frame longer than DEPTH; excess words discarded
//  missed     out  1      vin activity ignored while frame held/unarmed
//  dur        out  32     first-to-last-word cycle count (CAPTURE_STATS_EN only)
// BEHAVIOUR
//  Reset: state IDLE; frame_val, frame_len, ovf, missed, dur, gap counter, vin_q = 0.
//   rd_data registered, resets to 0. Buffer RAM not reset. rst mid-frame discards frame.
//  vin_q = vin delayed 1 cycle. Frame start = vin & !vin_q (rising edge only).
//  IDLE: start -> write din @0, len<=1, ovf<=0, missed<=0, -> RECV.
//   vin=1 without rising edge (ack mid-frame) -> no write, missed<=1, stay IDLE.
//  RECV: vin=1 -> if len<DEPTH write @len, len++; else ovf<=1, drop word, len holds.
//   vin=0 -> TIMEOUT==0: -> DONE; else gap<=1, -> GAP (or DONE if TIMEOUT==1).
//  GAP: vin=1 -> gap<=0, write/ovf as RECV, -> RECV.
//   vin=0 -> gap++; gap reaching TIMEOUT -> DONE.
//  DONE: frame_val=1 (registered, first high the cycle after end detected). No writes.
//   vin=1 -> missed<=1, data dropped. ack -> IDLE, frame_val<=0 next cycle;
//   frame_len/ovf/missed hold until next frame start. ack outside DONE ignored.
//   ack & vin same cycle: word dropped, missed<=1; new frame needs later rising edge.
//  Latency: TIMEOUT=0 -> frame_val high 2 cycles after last word; else TIMEOUT+1.
//  Readout: rd_data <= mem[rd_addr] every cycle; rd_addr>=frame_len returns stale RAM.
//  Gap counter width $clog2(TIMEOUT+1), never wraps (stops at TIMEOUT).
// CONFIGURATION
//  CAPTURE_STATS_EN defined: 32-bit cycle counter runs from frame start; dur latched with
//   cycles from first to last accepted vin cycle (1-word frame -> dur=0), valid with
//   frame_val, saturates at 2^32-1; cleared at frame start.
//  Not defined: counter absent, dur tied to 0.
// TESTING
//  T1 TIMEOUT=0: 5 words 0x11..0x15 contiguous -> frame_val 2 cycles later, len=5, rd 0..4 ok.
//  T2 TIMEOUT=4: 3 words, gap 3, 2 words -> one frame len=5; gap 4 -> frame_val, len=3.
//  T3 DEPTH=16: 20-word frame -> len=16, ovf=1, mem[15]=word 15; next frame clears ovf.
//  T4 vin burst during DONE, then ack while vin still high -> missed=1, no new frame until
//     vin low then high; following 2-word frame captured, len=2.
//  T5 rst asserted after 3 words -> all outputs 0, IDLE; next frame starts at addr 0.
//  T6 CAPTURE_STATS_EN, 8 contiguous words -> dur=7; with 2-cycle gap inside -> dur=9.

Source files
------------

// File: rtl/frame_capture_buf.sv
// rtl/frame_capture_buf.sv - vin-framed byte stream capture into a frozen buffer with idle-gap end detection
// Optional: CAPTURE_STATS_EN adds a first-to-last-word cycle count on dur.
module frame_capture_buf #(
  parameter int W       = 8,
  parameter int DEPTH   = 2048,
  parameter int TIMEOUT = 0,
  parameter int LEN_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     din,
  input  logic             vin,
  input  logic             ack,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [W-1:0]     rd_data,
  output logic             frame_val,
  output logic [LEN_W-1:0] frame_len,
  output logic             ovf,
  output logic             missed,
  output logic [31:0]      dur
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [GW-1:0]    GAP_LAST = GW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [W-1:0]     mem [0:DEPTH-1];
  logic [1:0]       state_q, state_d;
  logic             vin_q;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             missed_q, missed_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             fval_q;
  logic [W-1:0]     rd_data_q;
  logic             we;
  logic [AW-1:0]    waddr;
  logic             start;

  // Only a rising edge of vin opens a frame, so a stream left running across ack is not captured mid-way.
  assign start = vin & ~vin_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    missed_d = missed_q;
    gap_d    = gap_q;
    we       = 1'b0;
    waddr    = len_q[AW-1:0];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          we       = 1'b1;
          waddr    = '0;
          len_d    = LEN_W'(1);
          ovf_d    = 1'b0;
          missed_d = 1'b0;
          gap_d    = '0;
          state_d  = S_RECV;
        end else if (vin) begin
          missed_d = 1'b1;
        end
      end
      S_RECV, S_GAP: begin
        if (vin) begin
          gap_d   = '0;
          state_d = S_RECV;
          if (len_q < DEPTH_L) begin
            we    = 1'b1;
            len_d = len_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (state_q == S_RECV) begin
          gap_d   = GW'(1);
          state_d = (TIMEOUT <= 1) ? S_DONE : S_GAP;
        end else begin
          gap_d = gap_q + 1'b1;
          if (gap_q == GAP_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (vin) missed_d = 1'b1;
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vin_q    <= 1'b0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
      gap_q    <= '0;
      fval_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vin_q    <= vin;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      missed_q <= missed_d;
      gap_q    <= gap_d;
      fval_q   <= (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  // Addresses past the array keep the previous word rather than indexing out of range.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else if (rd_addr < DEPTH_L) rd_data_q <= mem[rd_addr[AW-1:0]];
  end

`ifdef CAPTURE_STATS_EN
  logic [31:0] cnt_q, dur_q, cnt_inc;
  logic        in_frame;

  assign in_frame = (state_q == S_RECV) || (state_q == S_GAP);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dur_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      cnt_q <= '0;
      dur_q <= '0;
    end else if (in_frame) begin
      cnt_q <= cnt_inc;
      if (vin) dur_q <= cnt_inc;
    end
  end

  assign dur = dur_q;
`else
  assign dur = '0;
`endif

  assign rd_data   = rd_data_q;
  assign frame_val = fval_q;
  assign frame_len = len_q;
  assign ovf       = ovf_q;
  assign missed    = missed_q;

endmodule

// File: tb/tb_frame_capture_buf.sv
// tb/tb_frame_capture_buf.sv - directed bench for frame_capture_buf (TIMEOUT=0 and TIMEOUT=4 instances, DEPTH=16)
module tb_frame_capture_buf;

  localparam int W = 8;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH + 1);
`ifdef CAPTURE_STATS_EN
  localparam int DUR8 = 7;
  localparam int DUR_GAP = 9;
`else
  localparam int DUR8 = 0;
  localparam int DUR_GAP = 0;
`endif

  logic          clk, rst, ack, vin0, vin4;
  logic [W-1:0]  din;
  logic [LW-1:0] rd_addr;
  logic [W-1:0]  rd_data0, rd_data4;
  logic          fv0, fv4, ovf0, ovf4, miss0, miss4;
  logic [LW-1:0] len0, len4;
  logic [31:0]   dur0, dur4;

  int n_checks = 0;
  int n_errors = 0;

  frame_capture_buf #(.W(W), .DEPTH(DEPTH), .TIMEOUT(0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .vin(vin0), .ack(ack), .rd_addr(rd_addr),
    .rd_data(rd_data0), .frame_val(fv0), .frame_len(len0), .ovf(ovf0),
    .missed(miss0), .dur(dur0)
  );

  frame_capture_buf #(.W(W), .DEPTH(DEPTH), .TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst(rst), .din(din), .vin(vin4), .ack(ack), .rd_addr(rd_addr),
    .rd_data(rd_data4), .frame_val(fv4), .frame_len(len4), .ovf(ovf4),
    .missed(miss4), .dur(dur4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [W-1:0] d);
    din = d;
    if (sel == 0) vin0 = 1'b1;
    else vin4 = 1'b1;
    tick();
  endtask

  task automatic stop_and_wait(input int n);
    vin0 = 1'b0;
    vin4 = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic rd(input int sel, input int a, input logic [W-1:0] exp, input string tag);
    rd_addr = LW'(a);
    tick();
    check(tag, (sel == 0) ? rd_data0 : rd_data4, exp);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; vin0 = 1'b0; vin4 = 1'b0; din = '0; rd_addr = '0;
    tick();
    tick();
    check("rst_fv0", fv0, 0);
    check("rst_len0", len0, 0);
    check("rst_ovf0", ovf0, 0);
    check("rst_miss0", miss0, 0);
    check("rst_rd0", rd_data0, 0);
    check("rst_fv4", fv4, 0);
    check("rst_dur4", dur4, 0);
    rst = 1'b0;
    tick();

    // T1: TIMEOUT=0, five contiguous words
    for (int i = 0; i < 5; i++) send(0, W'(8'h11 + i));
    vin0 = 1'b0;
    check("t1_fv_early", fv0, 0);
    tick();
    check("t1_fv", fv0, 1);
    check("t1_len", len0, 5);
    for (int i = 0; i < 5; i++) rd(0, i, W'(8'h11 + i), "t1_rd");

    // T3: overflow past DEPTH
    do_ack();
    check("t3_fv_ack", fv0, 0);
    for (int i = 0; i < 20; i++) send(0, W'(8'h40 + i));
    stop_and_wait(1);
    check("t3_fv", fv0, 1);
    check("t3_len", len0, 16);
    check("t3_ovf", ovf0, 1);
    rd(0, 15, 8'h4F, "t3_rd15");
    rd(0, 0, 8'h40, "t3_rd0");
    do_ack();
    send(0, 8'h99);
    check("t3_ovf_clr", ovf0, 0);
    check("t3_len_new", len0, 1);
    stop_and_wait(1);
    check("t3_fv_new", fv0, 1);

    // T4: activity while held, ack with vin high
    for (int i = 0; i < 3; i++) send(0, 8'hE0);
    check("t4_miss", miss0, 1);
    check("t4_fv_hold", fv0, 1);
    check("t4_len_hold", len0, 1);
    ack = 1'b1;
    send(0, 8'hEE);
    ack = 1'b0;
    check("t4_fv_ack", fv0, 0);
    send(0, 8'hEF);
    send(0, 8'hEF);
    check("t4_no_start_fv", fv0, 0);
    check("t4_no_start_len", len0, 1);
    check("t4_miss_held", miss0, 1);
    stop_and_wait(1);
    send(0, 8'h21);
    send(0, 8'h22);
    stop_and_wait(1);
    check("t4_fv", fv0, 1);
    check("t4_len", len0, 2);
    check("t4_miss_clr", miss0, 0);
    rd(0, 0, 8'h21, "t4_rd0");
    rd(0, 1, 8'h22, "t4_rd1");

    // T2: TIMEOUT=4, a 3-cycle gap stays inside the frame, 4 idle cycles close it
    for (int i = 0; i < 3; i++) send(1, W'(8'hA0 + i));
    stop_and_wait(3);
    check("t2_fv_gap3", fv4, 0);
    send(1, 8'hA3);
    send(1, 8'hA4);
    stop_and_wait(3);
    check("t2_fv_early", fv4, 0);
    tick();
    check("t2_fv", fv4, 1);
    check("t2_len", len4, 5);
    rd(1, 3, 8'hA3, "t2_rd3");
    rd(1, 4, 8'hA4, "t2_rd4");
    do_ack();
    for (int i = 0; i < 3; i++) send(1, W'(8'hB0 + i));
    stop_and_wait(4);
    check("t2b_fv", fv4, 1);
    check("t2b_len", len4, 3);

    // T6: duration statistic
    do_ack();
    for (int i = 0; i < 8; i++) send(0, W'(i));
    stop_and_wait(1);
    check("t6_fv0", fv0, 1);
    check("t6_dur8", dur0, DUR8);
    for (int i = 0; i < 4; i++) send(1, W'(8'hC0 + i));
    stop_and_wait(2);
    for (int i = 0; i < 4; i++) send(1, W'(8'hC4 + i));
    stop_and_wait(4);
    check("t6_fv4", fv4, 1);
    check("t6_len4", len4, 8);
    check("t6_dur_gap", dur4, DUR_GAP);

    // T5: reset mid-frame discards it
    do_ack();
    for (int i = 0; i < 3; i++) send(0, W'(8'h31 + i));
    rst = 1'b1;
    vin0 = 1'b0;
    tick();
    check("t5_fv0", fv0, 0);
    check("t5_len0", len0, 0);
    check("t5_ovf0", ovf0, 0);
    check("t5_miss0", miss0, 0);
    check("t5_rd0", rd_data0, 0);
    check("t5_len4", len4, 0);
    check("t5_dur4", dur4, 0);
    rst = 1'b0;
    tick();
    send(0, 8'h77);
    send(0, 8'h78);
    stop_and_wait(1);
    check("t5_fv", fv0, 1);
    check("t5_len", len0, 2);
    rd(0, 0, 8'h77, "t5_rd0_new");
    rd(0, 1, 8'h78, "t5_rd1_new");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
